// File: rtl/f1_pkg.sv
// Shared types and defaults for the F1 start-light sequencer.
package f1_pkg;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_LIGHTING = 2'd1,
        ST_HOLD     = 2'd2,
        ST_REACT    = 2'd3
    } state_t;

    localparam int N_LIGHTS_DEF = 8;
    localparam int RND_W_DEF    = 7;
    localparam int CNT_W_DEF    = 16;

    localparam logic [N_LIGHTS_DEF-1:0] ALL_LIT = '1;

endpackage

// File: rtl/f1_sequencer.sv
// Start-light sequencer: fills the gantry one lamp per tick, holds for a
// random tick count, blanks the lamps and times the driver's reaction.
//
//  state    | meaning
//  ---------+-----------------------------------------------------------
//  IDLE     | waiting for trigger, LFSR free-running
//  LIGHTING | one more lamp per tick until the gantry is full
//  HOLD     | full gantry, delay_reg ticks until blank
//  REACT    | lamps blanked, counting cycles until react
module f1_sequencer
    import f1_pkg::*;
#(
    parameter int N_LIGHTS = N_LIGHTS_DEF,
    parameter int RND_W    = RND_W_DEF,
    parameter int CNT_W    = CNT_W_DEF
) (
    input  logic                clk,
    input  logic                rst,
    input  logic                trigger,
    input  logic                tick,
    input  logic [RND_W-1:0]    rnd,
    input  logic                react,
    output logic                lfsr_en,
    output logic [N_LIGHTS-1:0] light,
    output logic                busy,
    output logic [CNT_W-1:0]    react_time,
    output logic                result_valid,
    output logic                jump_start
);

    // Gantry pattern one tick before full: every lamp lit except the MSB.
    localparam logic [N_LIGHTS-1:0] ALMOST_FULL = {1'b0, {(N_LIGHTS-1){1'b1}}};
    localparam logic [RND_W-1:0]    DELAY_ONE   = {{(RND_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0]    CNT_ONE     = {{(CNT_W-1){1'b0}}, 1'b1};

    state_t              state_q,        state_d;
    logic [N_LIGHTS-1:0] light_q,        light_d;
    logic [RND_W-1:0]    delay_q,        delay_d;
    logic [CNT_W-1:0]    react_cnt_q,    react_cnt_d;
    logic [CNT_W-1:0]    react_time_q,   react_time_d;
    logic                result_valid_q, result_valid_d;
    logic                jump_start_q,   jump_start_d;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q        <= ST_IDLE;
            light_q        <= '0;
            delay_q        <= DELAY_ONE;
            react_cnt_q    <= '0;
            react_time_q   <= '0;
            result_valid_q <= 1'b0;
            jump_start_q   <= 1'b0;
        end else begin
            state_q        <= state_d;
            light_q        <= light_d;
            delay_q        <= delay_d;
            react_cnt_q    <= react_cnt_d;
            react_time_q   <= react_time_d;
            result_valid_q <= result_valid_d;
            jump_start_q   <= jump_start_d;
        end
    end

    always_comb begin
        state_d        = state_q;
        light_d        = light_q;
        delay_d        = delay_q;
        react_cnt_d    = react_cnt_q;
        react_time_d   = react_time_q;
        result_valid_d = 1'b0;
        jump_start_d   = 1'b0;

        unique case (state_q)
            ST_IDLE: begin
                if (trigger) begin
                    // A zero draw would mean no hold at all; clamp to one tick.
                    delay_d = (rnd == '0) ? DELAY_ONE : rnd;
                    light_d = '0;
                    state_d = ST_LIGHTING;
                end
            end

            ST_LIGHTING: begin
                if (react) begin
                    light_d      = '0;
                    jump_start_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (tick) begin
                    light_d = {light_q[N_LIGHTS-2:0], 1'b1};
                    if (light_q == ALMOST_FULL) begin
                        state_d = ST_HOLD;
                    end
                end
            end

            ST_HOLD: begin
                if (react) begin
                    light_d      = '0;
                    jump_start_d = 1'b1;
                    state_d      = ST_IDLE;
                end else if (tick) begin
                    if (delay_q == DELAY_ONE) begin
                        light_d     = '0;
                        react_cnt_d = '0;
                        state_d     = ST_REACT;
                    end else begin
                        delay_d = delay_q - DELAY_ONE;
                    end
                end
            end

            ST_REACT: begin
                if (react_cnt_q != '1) begin
                    react_cnt_d = react_cnt_q + CNT_ONE;
                end
                if (react) begin
                    react_time_d   = react_cnt_q;
                    result_valid_d = 1'b1;
                    state_d        = ST_IDLE;
                end
            end

            default: begin
                state_d = ST_IDLE;
            end
        endcase
    end

    assign lfsr_en      = (state_q == ST_IDLE);
    assign busy         = (state_q != ST_IDLE);
    assign light        = light_q;
    assign react_time   = react_time_q;
    assign result_valid = result_valid_q;
    assign jump_start   = jump_start_q;

endmodule

// File: tb/tb_f1_sequencer.sv
// Bench for f1_sequencer: a vector table of per-cycle inputs/expected outputs
// plus hand-written long sequences, all checked through a scoreboard queue.
module tb_f1_sequencer;

    logic        clk;
    logic        rst;
    logic        trigger;
    logic        tick;
    logic [6:0]  rnd;
    logic        react;
    logic        lfsr_en;
    logic [7:0]  light;
    logic        busy;
    logic [15:0] react_time;
    logic        result_valid;
    logic        jump_start;

    f1_sequencer dut (
        .clk          (clk),
        .rst          (rst),
        .trigger      (trigger),
        .tick         (tick),
        .rnd          (rnd),
        .react        (react),
        .lfsr_en      (lfsr_en),
        .light        (light),
        .busy         (busy),
        .react_time   (react_time),
        .result_valid (result_valid),
        .jump_start   (jump_start)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    typedef struct packed {
        logic       rst;
        logic       trigger;
        logic       tick;
        logic       react;
        logic [6:0] rnd;
    } in_t;

    typedef struct packed {
        logic [7:0]  light;
        logic        busy;
        logic        lfsr_en;
        logic        rv;
        logic        js;
        logic [15:0] rt;
    } out_t;

    typedef struct {
        in_t  in;
        out_t exp;
    } vec_t;

    vec_t tbl[$];
    out_t sb[$];
    int   checks   = 0;
    int   failures = 0;
    int   row      = 0;

    function automatic vec_t mk(input logic r, input logic tg, input logic tk,
                                input logic rc, input logic [6:0] rn,
                                input logic [7:0] lt, input logic bz,
                                input logic le, input logic rv, input logic js,
                                input logic [15:0] rt);
        vec_t v;
        v.in  = '{rst: r, trigger: tg, tick: tk, react: rc, rnd: rn};
        v.exp = '{light: lt, busy: bz, lfsr_en: le, rv: rv, js: js, rt: rt};
        return v;
    endfunction

    function automatic logic [7:0] lit(input int n);
        logic [15:0] w;
        w = (16'd1 << n) - 16'd1;
        return w[7:0];
    endfunction

    task automatic step(input vec_t v);
        out_t act;
        out_t exp;
        rst     = v.in.rst;
        trigger = v.in.trigger;
        tick    = v.in.tick;
        react   = v.in.react;
        rnd     = v.in.rnd;
        sb.push_back(v.exp);
        @(posedge clk);
        #1;
        act = '{light: light, busy: busy, lfsr_en: lfsr_en, rv: result_valid,
                js: jump_start, rt: react_time};
        exp = sb.pop_front();
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL row%0d: light=%h busy=%b lfsr_en=%b rv=%b js=%b rt=%h, required light=%h busy=%b lfsr_en=%b rv=%b js=%b rt=%h",
                     row, act.light, act.busy, act.lfsr_en, act.rv, act.js, act.rt,
                     exp.light, exp.busy, exp.lfsr_en, exp.rv, exp.js, exp.rt);
        end
        row++;
    endtask

    initial begin
        rst = 1'b1; trigger = 1'b0; tick = 1'b0; react = 1'b0; rnd = '0;

        // Reset, then a quiet idle stretch with ignored tick/react.
        repeat (2) tbl.push_back(mk(1,0,0,0,0, 8'h00,0,1,0,0,16'd0));
        for (int i = 0; i < 20; i++)
            tbl.push_back(mk(0,0,i[0],(i==7),0, 8'h00,0,1,0,0,16'd0));

        // rnd=3: fill the gantry, hold three ticks, blank.
        tbl.push_back(mk(0,1,0,0,3, 8'h00,1,0,0,0,16'd0));
        for (int i = 0; i < 8; i++) begin
            tbl.push_back(mk(0,(i==2),1,0,0, lit(i+1),1,0,0,0,16'd0));
            if (i == 4) tbl.push_back(mk(0,0,0,0,0, lit(5),1,0,0,0,16'd0));
        end
        tbl.push_back(mk(0,0,1,0,0, 8'hFF,1,0,0,0,16'd0));
        tbl.push_back(mk(0,0,0,0,0, 8'hFF,1,0,0,0,16'd0));
        tbl.push_back(mk(0,0,1,0,0, 8'hFF,1,0,0,0,16'd0));
        tbl.push_back(mk(0,0,1,0,0, 8'h00,1,0,0,0,16'd0));
        // React on the 50th cycle after blank; tick/trigger ignored meanwhile.
        for (int i = 1; i < 50; i++)
            tbl.push_back(mk(0,(i==10),(i%3==0),0,0, 8'h00,1,0,0,0,16'd0));
        tbl.push_back(mk(0,0,0,1,0, 8'h00,0,1,1,0,16'd49));
        tbl.push_back(mk(0,0,0,0,0, 8'h00,0,1,0,0,16'd49));

        // trigger+react in IDLE: trigger wins. Jump start at 0F, trigger ignored.
        tbl.push_back(mk(0,1,0,1,5, 8'h00,1,0,0,0,16'd49));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,1,0,0, lit(i+1),1,0,0,0,16'd49));
        tbl.push_back(mk(0,1,0,1,0, 8'h00,0,1,0,1,16'd49));
        tbl.push_back(mk(0,0,0,0,0, 8'h00,0,1,0,0,16'd49));

        // rnd=0 holds exactly one tick; react 5 cycles after blank gives 4.
        tbl.push_back(mk(0,1,0,0,0, 8'h00,1,0,0,0,16'd49));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,1,0,0, lit(i+1),1,0,0,0,16'd49));
        tbl.push_back(mk(0,0,1,0,0, 8'h00,1,0,0,0,16'd49));
        for (int i = 0; i < 4; i++)
            tbl.push_back(mk(0,0,0,0,0, 8'h00,1,0,0,0,16'd49));
        tbl.push_back(mk(0,0,0,1,0, 8'h00,0,1,1,0,16'd4));
        tbl.push_back(mk(0,0,0,0,0, 8'h00,0,1,0,0,16'd4));

        // react+tick together in HOLD is a jump start.
        tbl.push_back(mk(0,1,0,0,2, 8'h00,1,0,0,0,16'd4));
        for (int i = 0; i < 8; i++)
            tbl.push_back(mk(0,0,1,0,0, lit(i+1),1,0,0,0,16'd4));
        tbl.push_back(mk(0,0,1,1,0, 8'h00,0,1,0,1,16'd4));
        tbl.push_back(mk(0,0,0,0,0, 8'h00,0,1,0,0,16'd4));

        foreach (tbl[i]) step(tbl[i]);

        // Reaction counter saturation.
        step(mk(0,1,0,0,1, 8'h00,1,0,0,0,16'd4));
        for (int i = 0; i < 8; i++) step(mk(0,0,1,0,0, lit(i+1),1,0,0,0,16'd4));
        step(mk(0,0,1,0,0, 8'h00,1,0,0,0,16'd4));
        for (int i = 0; i < 70000; i++) step(mk(0,0,0,0,0, 8'h00,1,0,0,0,16'd4));
        step(mk(0,0,0,1,0, 8'h00,0,1,1,0,16'hFFFF));
        step(mk(0,0,0,0,0, 8'h00,0,1,0,0,16'hFFFF));

        // Reset in HOLD, with react and tick present: no pulses, all cleared.
        step(mk(0,1,0,0,100, 8'h00,1,0,0,0,16'hFFFF));
        for (int i = 0; i < 8; i++) step(mk(0,0,1,0,0, lit(i+1),1,0,0,0,16'hFFFF));
        step(mk(0,0,1,0,0, 8'hFF,1,0,0,0,16'hFFFF));
        step(mk(1,0,1,1,0, 8'h00,0,1,0,0,16'd0));
        step(mk(0,0,0,0,0, 8'h00,0,1,0,0,16'd0));

        if (sb.size() != 0) begin
            failures++;
            $display("FAIL scoreboard_drain: left=%0d required=0", sb.size());
        end
        checks++;

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
